// File: rtl/cpu_clk_sequencer.sv
// Gated CPU clock sequencer: issues one full clk period at a time from sysclk and
// emits staggered one-sysclk probe strobes near the end of every CPU cycle.
module cpu_clk_sequencer #(
    parameter int unsigned HALF_PERIOD = 500,
    parameter int unsigned NUM_PROBES  = 4,
    parameter int unsigned PROBE_LEAD  = 10,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  step_req,
    input  logic [CNT_W-1:0]      max_cycles,
    input  logic                  cnt_clr,
    output logic                  clk,
    output logic [NUM_PROBES-1:0] probe_pulse,
    output logic [CNT_W-1:0]      cycle_count,
    output logic                  running,
    output logic                  done
);
    localparam int unsigned   PERIOD      = 2 * HALF_PERIOD;
    localparam int unsigned   TW          = $clog2(PERIOD);
    localparam int unsigned   PROBE_FIRST = PERIOD - PROBE_LEAD;
    localparam logic [TW-1:0] T_LAST      = TW'(PERIOD - 1);
    localparam logic [1:0]    MODE_RUN    = 2'd1;
    localparam logic [1:0]    MODE_STEP   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [TW-1:0]    t;
    logic [TW-1:0]    t_inc;
    logic             step_q;
    logic             step_pending;
    logic             clr_pending;
    logic             step_edge;
    logic             decide;
    logic             want;
    logic             at_limit;
    logic             start;
    logic             mode_halt;
    logic [CNT_W-1:0] count_base;

    // Probe vector for a given tick of the period
    function automatic logic [NUM_PROBES-1:0] probe_at(input logic [TW-1:0] tick);
        logic [NUM_PROBES-1:0] p;
        p = '0;
        for (int unsigned k = 0; k < NUM_PROBES; k++) begin
            p[k] = (32'(tick) == (PROBE_FIRST + k));
        end
        return p;
    endfunction

    // Decision-point evaluation; a pending in-period clear makes the count restart from zero
    always_comb begin
        step_edge  = step_req & ~step_q;
        decide     = (state == S_IDLE) || ((state == S_ACTIVE) && (t == T_LAST));
        count_base = (cnt_clr || clr_pending) ? '0 : cycle_count;
        at_limit   = (max_cycles != '0) && (count_base == max_cycles);
        want       = (mode == MODE_RUN) || ((mode == MODE_STEP) && step_pending);
        start      = decide && want && !at_limit;
        mode_halt  = (mode != MODE_RUN) && (mode != MODE_STEP);
        t_inc      = t + TW'(1);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            t            <= '0;
            clk          <= 1'b0;
            probe_pulse  <= '0;
            cycle_count  <= '0;
            running      <= 1'b0;
            done         <= 1'b0;
            step_q       <= 1'b0;
            step_pending <= 1'b0;
            clr_pending  <= 1'b0;
        end else begin
            step_q <= step_req;

            // One-deep step request; set wins over consumption in the same cycle
            if (mode != MODE_STEP) begin
                step_pending <= 1'b0;
            end else if (step_edge) begin
                step_pending <= 1'b1;
            end else if (start) begin
                step_pending <= 1'b0;
            end

            case (state)
                S_IDLE, S_ACTIVE: begin
                    if (start) begin
                        state       <= S_ACTIVE;
                        t           <= '0;
                        clk         <= 1'b1;
                        probe_pulse <= probe_at('0);
                        running     <= 1'b1;
                        cycle_count <= count_base + CNT_W'(1);
                        clr_pending <= 1'b0;
                    end else if (!decide) begin
                        t           <= t_inc;
                        clk         <= (32'(t_inc) < HALF_PERIOD);
                        probe_pulse <= probe_at(t_inc);
                        if (cnt_clr) begin
                            clr_pending <= 1'b1;
                        end
                    end else begin
                        t           <= '0;
                        clk         <= 1'b0;
                        probe_pulse <= '0;
                        running     <= 1'b0;
                        cycle_count <= count_base;
                        clr_pending <= 1'b0;
                        // Wanting to start but not starting means the limit was hit
                        if (want) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (cnt_clr || mode_halt) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        if (cnt_clr) begin
                            cycle_count <= '0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Bench for cpu_clk_sequencer: two instances (full-size and tiny wrap-around) share one
// stimulus stream and are compared every cycle against an elapsed-time reference model.
module tb_cpu_clk_sequencer;
    localparam int unsigned A_HALF = 500;
    localparam int unsigned A_LEAD = 10;
    localparam int unsigned B_HALF = 4;
    localparam int unsigned B_LEAD = 4;
    localparam int unsigned B_CW   = 3;

    localparam int ST_IDLE = 0;
    localparam int ST_ACT  = 1;
    localparam int ST_DONE = 2;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [1:0]  mode   = 2'd0;
    logic        step_req = 1'b0;
    logic [31:0] max_cycles = '0;
    logic        cnt_clr = 1'b0;

    logic        clk_a, running_a, done_a;
    logic [3:0]  probe_a;
    logic [31:0] count_a;
    logic        clk_b, running_b, done_b;
    logic [3:0]  probe_b;
    logic [2:0]  count_b;

    int n_cmp = 0;
    int n_err = 0;
    int rises_a = 0;
    logic prev_clk_a = 1'b0;

    int     m_st    [2];
    longint m_start [2];
    longint m_cnt   [2];
    bit     m_done  [2];
    bit     m_pend  [2];
    bit     m_clrp  [2];
    bit     m_sq    [2];
    longint cyc = 0;

    cpu_clk_sequencer #(
        .HALF_PERIOD(A_HALF), .NUM_PROBES(4), .PROBE_LEAD(A_LEAD), .CNT_W(32)
    ) u_dut_a (
        .sysclk(sysclk), .reset(reset), .mode(mode), .step_req(step_req),
        .max_cycles(max_cycles), .cnt_clr(cnt_clr), .clk(clk_a),
        .probe_pulse(probe_a), .cycle_count(count_a), .running(running_a), .done(done_a)
    );

    cpu_clk_sequencer #(
        .HALF_PERIOD(B_HALF), .NUM_PROBES(4), .PROBE_LEAD(B_LEAD), .CNT_W(B_CW)
    ) u_dut_b (
        .sysclk(sysclk), .reset(reset), .mode(mode), .step_req(step_req),
        .max_cycles(max_cycles[2:0]), .cnt_clr(cnt_clr), .clk(clk_b),
        .probe_pulse(probe_b), .cycle_count(count_b), .running(running_b), .done(done_b)
    );

    always #5 sysclk = ~sysclk;

    function automatic longint hp(input int i);
        return (i == 0) ? longint'(A_HALF) : longint'(B_HALF);
    endfunction

    function automatic longint ld(input int i);
        return (i == 0) ? longint'(A_LEAD) : longint'(B_LEAD);
    endfunction

    function automatic longint cmask(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : ((longint'(1) << B_CW) - 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = ST_IDLE; m_start[i] = 0; m_cnt[i] = 0;
            m_done[i] = 0; m_pend[i] = 0; m_clrp[i] = 0; m_sq[i] = 0;
        end
    endtask

    // One sysclk of the spec's rules, using the inputs that were stable at that edge
    task automatic model_step(input int i);
        longint tt, base, mx;
        bit dec, want, lim, edge_s, consumed;
        mx       = longint'(max_cycles) & cmask(i);
        tt       = cyc - m_start[i];
        dec      = (m_st[i] == ST_IDLE) || ((m_st[i] == ST_ACT) && (tt == 2 * hp(i) - 1));
        base     = (cnt_clr || m_clrp[i]) ? 0 : m_cnt[i];
        want     = (mode == 2'd1) || ((mode == 2'd2) && m_pend[i]);
        lim      = (mx != 0) && (base == mx);
        edge_s   = step_req && !m_sq[i];
        consumed = 0;
        if (m_st[i] == ST_DONE) begin
            if (cnt_clr || mode == 2'd0 || mode == 2'd3) begin
                m_st[i] = ST_IDLE;
                m_done[i] = 0;
                if (cnt_clr) m_cnt[i] = 0;
            end
        end else if (dec) begin
            if (want && !lim) begin
                m_st[i]    = ST_ACT;
                m_start[i] = cyc + 1;
                m_cnt[i]   = (base + 1) & cmask(i);
                consumed   = (mode == 2'd2);
            end else begin
                m_cnt[i]  = base;
                m_st[i]   = want ? ST_DONE : ST_IDLE;
                m_done[i] = want;
            end
            m_clrp[i] = 0;
        end else if (cnt_clr) begin
            m_clrp[i] = 1;
        end
        if (mode != 2'd2) m_pend[i] = 0;
        else if (edge_s) m_pend[i] = 1;
        else if (consumed) m_pend[i] = 0;
        m_sq[i] = step_req;
    endtask

    function automatic logic [63:0] model_outs(input int i);
        logic c, r;
        logic [3:0] p;
        longint tt;
        c = 1'b0; r = 1'b0; p = '0;
        if (m_st[i] == ST_ACT) begin
            tt = cyc - m_start[i];
            c  = (tt < hp(i));
            r  = 1'b1;
            for (int k = 0; k < 4; k++) p[k] = (tt == 2 * hp(i) - ld(i) + longint'(k));
        end
        return 64'({c, r, logic'(m_done[i]), p, 32'(m_cnt[i])});
    endfunction

    // Advance n cycles; model and compare on each falling edge, before new inputs are driven
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sysclk);
            if (!reset) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
                cyc++;
            end
            check("outs_a", 64'({clk_a, running_a, done_a, probe_a, count_a}), model_outs(0));
            check("outs_b", 64'({clk_b, running_b, done_b, probe_b, 32'(count_b)}), model_outs(1));
            if (clk_a && !prev_clk_a) rises_a++;
            prev_clk_a = clk_a;
        end
    endtask

    initial begin
        int r;
        model_reset();
        #1 reset = 1'b0;
        tick(3);
        check("rst_clk", 64'(clk_a), 64'(0));
        check("rst_count", 64'(count_a), 64'(0));
        reset = 1'b1;
        tick(2);

        // Free-running, unlimited: probe order and count
        mode = 2'd1; rises_a = 0;
        tick(991); check("probe_inst", 64'(probe_a), 64'(4'b0001));
        tick(1);   check("probe_alu", 64'(probe_a), 64'(4'b0010));
        tick(1);   check("probe_mem", 64'(probe_a), 64'(4'b0100));
        tick(1);   check("probe_reg", 64'(probe_a), 64'(4'b1000));
        tick(1);   check("probe_off", 64'(probe_a), 64'(0));
        tick(2005);
        check("run_count", 64'(count_a), 64'(3));
        check("run_rises", 64'(rises_a), 64'(3));

        // Limit of 5 with an in-period clear: count restarts at 1
        max_cycles = 32'd5; cnt_clr = 1'b1; rises_a = 0;
        tick(1); cnt_clr = 1'b0;
        check("clr_restart", 64'(count_a), 64'(1));
        tick(4999);
        check("lim_last_running", 64'(running_a), 64'(1));
        tick(2);
        check("lim_done", 64'(done_a), 64'(1));
        check("lim_clk", 64'(clk_a), 64'(0));
        check("lim_running", 64'(running_a), 64'(0));
        check("lim_count", 64'(count_a), 64'(5));
        check("lim_rises", 64'(rises_a), 64'(5));
        mode = 2'd0;
        tick(2);
        check("halt_done", 64'(done_a), 64'(0));

        // Single-step: two edges give back-to-back periods, a third gives one more
        max_cycles = '0; mode = 2'd2;
        tick(2); rises_a = 0;
        step_req = 1'b1; tick(5); step_req = 1'b0; tick(5);
        step_req = 1'b1; tick(5); step_req = 1'b0;
        tick(2100);
        check("step_count", 64'(count_a), 64'(7));
        check("step_idle_clk", 64'(clk_a), 64'(0));
        check("step_rises", 64'(rises_a), 64'(2));
        step_req = 1'b1; tick(5); step_req = 1'b0;
        tick(1100);
        check("step3_count", 64'(count_a), 64'(8));

        // Halt mid-period: period completes with its probes
        mode = 2'd1;
        tick(201); mode = 2'd0;
        tick(790);
        check("halt_probe", 64'(probe_a), 64'(4'b0001));
        tick(110);
        check("halt_count", 64'(count_a), 64'(9));
        check("halt_running", 64'(running_a), 64'(0));

        // Reset mid-period, then restart in RUN; small instance wraps on its 8th rise
        mode = 2'd1;
        tick(251);
        check("pre_rst_clk", 64'(clk_a), 64'(1));
        reset = 1'b0;
        tick(1);
        check("mid_rst_clk", 64'(clk_a), 64'(0));
        check("mid_rst_count", 64'(count_a), 64'(0));
        tick(2);
        reset = 1'b1;
        tick(1);
        check("rel_clk", 64'(clk_a), 64'(1));
        check("rel_count", 64'(count_a), 64'(1));
        tick(56);
        check("wrap_b", 64'(count_b), 64'(0));
        mode = 2'd0;
        tick(1100);

        // Randomized phase
        for (int it = 0; it < 1200; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20) begin
                mode = 2'($urandom_range(0, 3));
            end else if (r < 45) begin
                step_req = ~step_req;
            end else if (r < 55) begin
                max_cycles = 32'($urandom_range(0, 9));
            end else if (r < 62) begin
                cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
            end else if (r < 64) begin
                reset = 1'b0; tick(int'($urandom_range(1, 3))); reset = 1'b1;
            end
            tick(int'($urandom_range(1, 16)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
